// File: rtl/forward_multiport_pkg.sv
// forward_multiport shared definitions
// state encoding, host-bit index and bitmap sizing
package forward_multiport_pkg;

  localparam int DEF_PORT_NUM = 8;
  localparam int DEF_BUFID_W  = 9;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_DISPATCH = 1'b1;

  localparam int DEF_HOST_BIT = DEF_PORT_NUM;

  function automatic int bmp_w(input int port_num);
    return port_num + 1;
  endfunction

  function automatic int host_bit(input int port_num);
    return port_num;
  endfunction

endpackage

// File: rtl/forward_multiport_if.sv
// forward_multiport descriptor channel
// descriptor fields, bitmap sources and accept handshake
interface forward_multiport_if #(
  parameter int PORT_NUM = 8,
  parameter int BUFID_W  = 9
) ();

  logic                 i_desc_valid;
  logic                 o_desc_ready;
  logic [BUFID_W-1:0]   iv_pkt_bufid;
  logic [2:0]           iv_pkt_type;
  logic [4:0]           iv_submit_addr;
  logic [3:0]           iv_inport;
  logic                 i_outport_wr;
  logic [PORT_NUM:0]    iv_outport;
  logic [PORT_NUM:0]    iv_ram_rdata;
  logic                 i_miss_mode;

  modport master (
    output i_desc_valid,
    output iv_pkt_bufid,
    output iv_pkt_type,
    output iv_submit_addr,
    output iv_inport,
    output i_outport_wr,
    output iv_outport,
    output iv_ram_rdata,
    output i_miss_mode,
    input  o_desc_ready
  );

  modport slave (
    input  i_desc_valid,
    input  iv_pkt_bufid,
    input  iv_pkt_type,
    input  iv_submit_addr,
    input  iv_inport,
    input  i_outport_wr,
    input  iv_outport,
    input  iv_ram_rdata,
    input  i_miss_mode,
    output o_desc_ready
  );

endinterface

// File: rtl/forward_port_slot.sv
// forward_port_slot: one output channel's pending bit
// valid follows pending; cleared once the port accepts
module forward_port_slot (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_set,
  input  logic i_ready,
  output logic o_valid
);

  logic pend_q;

  // load on descriptor accept, drop once valid meets ready
  always_ff @(posedge i_clk) begin
    if (i_rst)
      pend_q <= 1'b0;
    else if (i_load)
      pend_q <= i_set;
    else if (pend_q && i_ready)
      pend_q <= 1'b0;
  end

  assign o_valid = pend_q;

endmodule

// File: rtl/forward_multiport.sv
// forward_multiport: replicate one descriptor to a port bitmap
// and report the replica count to the buffer manager
module forward_multiport
  import forward_multiport_pkg::*;
#(
  parameter int PORT_NUM = DEF_PORT_NUM,
  parameter int BUFID_W  = DEF_BUFID_W,
  parameter int CNT_W    = 5
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  forward_multiport_if.slave          desc,
  output logic [PORT_NUM*BUFID_W-1:0] ov_pkt_bufid_p,
  output logic [PORT_NUM*3-1:0]       ov_pkt_type_p,
  output logic [PORT_NUM-1:0]         ov_pkt_bufid_wr_p,
  input  logic [PORT_NUM-1:0]         iv_port_ready,
  output logic [BUFID_W-1:0]          ov_pkt_bufid_host,
  output logic [2:0]                  ov_pkt_type_host,
  output logic [4:0]                  ov_submit_addr_host,
  output logic [3:0]                  ov_inport_host,
  output logic                        o_pkt_bufid_wr_host,
  input  logic                        i_host_ready,
  output logic [BUFID_W-1:0]          ov_pkt_bufid,
  output logic                        o_pkt_bufid_wr,
  output logic [CNT_W-1:0]            ov_pkt_bufid_cnt,
  output logic [15:0]                 ov_fwd_cnt,
  output logic [15:0]                 ov_drop_cnt
);

  localparam int BW = bmp_w(PORT_NUM);
  localparam int HB = host_bit(PORT_NUM);

  logic [0:0]         state_q;
  logic               rdy_q;
  logic [BW-1:0]      pend;
  logic [BW-1:0]      port_rdy;
  logic [BW-1:0]      bmp_sel;
  logic [BW-1:0]      bmp_eff;
  logic               acc;
  logic               miss;
  logic               drop;
  logic               load;
  logic               done;
  logic               disp;
  logic [CNT_W-1:0]   pcnt;
  logic [BUFID_W-1:0] bufid_q;
  logic [2:0]         type_q;
  logic [4:0]         addr_q;
  logic [3:0]         inport_q;
  logic [BUFID_W-1:0] bm_bufid_q;
  logic               bm_wr_q;
  logic [CNT_W-1:0]   bm_cnt_q;
  logic [15:0]        fwd_q;
  logic [15:0]        drop_q;

  assign port_rdy = {i_host_ready, iv_port_ready};
  assign disp     = (state_q == ST_DISPATCH);
  assign acc      = desc.i_desc_valid & rdy_q;
  assign bmp_sel  = desc.i_outport_wr ? desc.iv_outport
                                      : desc.iv_ram_rdata;
  assign miss     = (bmp_sel == '0);
  assign drop     = acc & miss & desc.i_miss_mode;
  assign load     = acc & ~drop;
  assign done     = disp & ((pend & ~port_rdy) == '0);

  // a missed lookup that is not dropped goes to the host only
  always_comb begin
    bmp_eff = bmp_sel;
    if (miss) begin
      bmp_eff     = '0;
      bmp_eff[HB] = 1'b1;
    end
  end

  // replica count, sized so a full bitmap cannot overflow
  always_comb begin
    pcnt = '0;
    for (int i = 0; i < BW; i++)
      pcnt = pcnt + CNT_W'(bmp_eff[i]);
  end

  // IDLE/DISPATCH control; ready is its own register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
    end else if (load) begin
      state_q <= ST_DISPATCH;
      rdy_q   <= 1'b0;
    end else if (done) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b1;
    end else if (!disp) begin
      rdy_q   <= 1'b1;
    end
  end

  // descriptor fields held for the whole dispatch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bufid_q  <= '0;
      type_q   <= '0;
      addr_q   <= '0;
      inport_q <= '0;
    end else if (load) begin
      bufid_q  <= desc.iv_pkt_bufid;
      type_q   <= desc.iv_pkt_type;
      addr_q   <= desc.iv_submit_addr;
      inport_q <= desc.iv_inport;
    end
  end

  // one-cycle replica-count report; count 0 frees a drop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bm_wr_q    <= 1'b0;
      bm_bufid_q <= '0;
      bm_cnt_q   <= '0;
    end else begin
      bm_wr_q <= acc;
      if (acc) begin
        bm_bufid_q <= desc.iv_pkt_bufid;
        bm_cnt_q   <= drop ? '0 : pcnt;
      end
    end
  end

  // forwarded / dropped statistics, free-running wrap
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fwd_q  <= '0;
      drop_q <= '0;
    end else begin
      if (done) fwd_q  <= fwd_q + 16'd1;
      if (drop) drop_q <= drop_q + 16'd1;
    end
  end

  for (genvar g = 0; g < BW; g++) begin : g_slot
    forward_port_slot u_slot (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (load),
      .i_set   (bmp_eff[g]),
      .i_ready (port_rdy[g]),
      .o_valid (pend[g])
    );
  end

  assign desc.o_desc_ready   = rdy_q;

  assign ov_pkt_bufid_wr_p   = pend[PORT_NUM-1:0];
  assign o_pkt_bufid_wr_host = pend[HB];

  assign ov_pkt_bufid_p      = disp ? {PORT_NUM{bufid_q}} : '0;
  assign ov_pkt_type_p       = disp ? {PORT_NUM{type_q}}  : '0;
  assign ov_pkt_bufid_host   = disp ? bufid_q  : '0;
  assign ov_pkt_type_host    = disp ? type_q   : '0;
  assign ov_submit_addr_host = disp ? addr_q   : '0;
  assign ov_inport_host      = disp ? inport_q : '0;

  assign ov_pkt_bufid        = bm_bufid_q;
  assign o_pkt_bufid_wr      = bm_wr_q;
  assign ov_pkt_bufid_cnt    = bm_cnt_q;
  assign ov_fwd_cnt          = fwd_q;
  assign ov_drop_cnt         = drop_q;

endmodule

// File: tb/tb_forward_multiport.sv
// tb_forward_multiport: directed + random stimulus
// against a transaction-level model of the forwarder
module tb_forward_multiport;
  import forward_multiport_pkg::*;

  localparam int PN = 8;
  localparam int BW = 9;
  localparam int CW = 5;
  localparam int NB = PN + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  forward_multiport_if #(.PORT_NUM(PN), .BUFID_W(BW)) dif ();

  logic [PN*BW-1:0] bufid_p;
  logic [PN*3-1:0]  type_p;
  logic [PN-1:0]    wr_p;
  logic [PN-1:0]    port_rdy;
  logic [BW-1:0]    h_bufid;
  logic [2:0]       h_type;
  logic [4:0]       h_addr;
  logic [3:0]       h_inport;
  logic             h_wr;
  logic             host_rdy;
  logic [BW-1:0]    bm_bufid;
  logic             bm_wr;
  logic [CW-1:0]    bm_cnt;
  logic [15:0]      fwd_cnt;
  logic [15:0]      drop_cnt;

  forward_multiport #(
    .PORT_NUM(PN), .BUFID_W(BW), .CNT_W(CW)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .desc                (dif),
    .ov_pkt_bufid_p      (bufid_p),
    .ov_pkt_type_p       (type_p),
    .ov_pkt_bufid_wr_p   (wr_p),
    .iv_port_ready       (port_rdy),
    .ov_pkt_bufid_host   (h_bufid),
    .ov_pkt_type_host    (h_type),
    .ov_submit_addr_host (h_addr),
    .ov_inport_host      (h_inport),
    .o_pkt_bufid_wr_host (h_wr),
    .i_host_ready        (host_rdy),
    .ov_pkt_bufid        (bm_bufid),
    .o_pkt_bufid_wr      (bm_wr),
    .ov_pkt_bufid_cnt    (bm_cnt),
    .ov_fwd_cnt          (fwd_cnt),
    .ov_drop_cnt         (drop_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic cmp(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: outstanding replicas as a set of port bits
  logic [NB-1:0] m_pend  = '0;
  bit            m_rdy   = 1'b0;
  bit            m_wr    = 1'b0;
  logic [BW-1:0] m_bo    = '0;
  logic [CW-1:0] m_cnt   = '0;
  logic [BW-1:0] m_bufid = '0;
  logic [2:0]    m_type  = '0;
  logic [4:0]    m_addr  = '0;
  logic [3:0]    m_inp   = '0;
  logic [15:0]   m_fwd   = '0;
  logic [15:0]   m_drop  = '0;
  int            total_fwd = 0;

  // advance the model on every clock edge
  always @(posedge clk) begin
    logic [NB-1:0] bm;
    logic [NB-1:0] rv;
    rv = {host_rdy, port_rdy};
    m_wr = 1'b0;
    if (rst) begin
      m_pend = '0;
      m_rdy  = 1'b0;
      m_fwd  = '0;
      m_drop = '0;
    end else if (m_pend != '0) begin
      m_pend = m_pend & ~rv;
      if (m_pend == '0) begin
        m_fwd = m_fwd + 16'd1;
        total_fwd++;
        m_rdy = 1'b1;
      end
    end else if (m_rdy && dif.i_desc_valid) begin
      bm = dif.i_outport_wr ? dif.iv_outport : dif.iv_ram_rdata;
      m_wr = 1'b1;
      m_bo = dif.iv_pkt_bufid;
      if (bm == '0 && dif.i_miss_mode) begin
        m_cnt  = '0;
        m_drop = m_drop + 16'd1;
      end else begin
        if (bm == '0) begin
          bm     = '0;
          bm[PN] = 1'b1;
        end
        m_pend  = bm;
        m_cnt   = CW'($countones(bm));
        m_bufid = dif.iv_pkt_bufid;
        m_type  = dif.iv_pkt_type;
        m_addr  = dif.iv_submit_addr;
        m_inp   = dif.iv_inport;
        m_rdy   = 1'b0;
      end
    end else begin
      m_rdy = 1'b1;
    end
  end

  // compare DUT against the model away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("desc_ready", dif.o_desc_ready, m_rdy);
      cmp("bm_wr", bm_wr, m_wr);
      if (m_wr) begin
        cmp("bm_bufid", bm_bufid, m_bo);
        cmp("bm_cnt", bm_cnt, m_cnt);
      end
      cmp("port_valid", wr_p, m_pend[PN-1:0]);
      cmp("host_valid", h_wr, m_pend[PN]);
      cmp("fwd_cnt", fwd_cnt, m_fwd);
      cmp("drop_cnt", drop_cnt, m_drop);
      if (m_pend == '0) begin
        cmp("idle_bufid_p", bufid_p, '0);
        cmp("idle_type_p", type_p, '0);
        cmp("idle_host", {h_bufid, h_type, h_addr, h_inport}, '0);
      end else begin
        for (int j = 0; j < PN; j++) begin
          if (m_pend[j]) begin
            cmp("port_bufid", bufid_p[j*BW +: BW], m_bufid);
            cmp("port_type", type_p[j*3 +: 3], m_type);
          end
        end
        if (m_pend[PN]) begin
          cmp("host_bufid", h_bufid, m_bufid);
          cmp("host_type", h_type, m_type);
          cmp("host_addr", h_addr, m_addr);
          cmp("host_inport", h_inport, m_inp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] b,
                      input logic [2:0]    t,
                      input logic [4:0]    a,
                      input logic [3:0]    ip,
                      input logic          owr,
                      input logic [NB-1:0] op,
                      input logic [NB-1:0] rd,
                      input logic          miss);
    dif.iv_pkt_bufid   = b;
    dif.iv_pkt_type    = t;
    dif.iv_submit_addr = a;
    dif.iv_inport      = ip;
    dif.i_outport_wr   = owr;
    dif.iv_outport     = op;
    dif.iv_ram_rdata   = rd;
    dif.i_miss_mode    = miss;
    dif.i_desc_valid   = 1'b1;
    for (int i = 0; i < 64 && !m_rdy; i++) tick();
    cmp("send_wait", m_rdy, 1'b1);
    tick();
    dif.i_desc_valid = 1'b0;
  endtask

  initial begin
    int start;
    dif.i_desc_valid   = 1'b0;
    dif.iv_pkt_bufid   = '0;
    dif.iv_pkt_type    = '0;
    dif.iv_submit_addr = '0;
    dif.iv_inport      = '0;
    dif.i_outport_wr   = 1'b0;
    dif.iv_outport     = '0;
    dif.iv_ram_rdata   = '0;
    dif.i_miss_mode    = 1'b0;
    port_rdy = '1;
    host_rdy = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk_on = 1'b1;
    cmp("rst_ready", dif.o_desc_ready, 1'b0);
    cmp("rst_fwd", fwd_cnt, 16'd0);
    rst = 1'b0;
    tick();
    cmp("post_rst_ready", dif.o_desc_ready, 1'b1);

    // direct bitmap 0x005
    send(9'h055, 3'd2, 5'd3, 4'd1, 1'b1, 9'h005, 9'h1FF, 1'b0);
    cmp("s1_valid", wr_p, 8'h05);
    cmp("s1_host", h_wr, 1'b0);
    cmp("s1_bm_wr", bm_wr, 1'b1);
    cmp("s1_cnt", bm_cnt, 5'd2);
    cmp("s1_bufid_p2", bufid_p[2*BW +: BW], 9'h055);
    tick();
    cmp("s1_valid_off", wr_p, 8'h00);
    cmp("s1_ready", dif.o_desc_ready, 1'b1);
    cmp("s1_fwd", fwd_cnt, 16'd1);

    // lookup miss to host
    send(9'h1A3, 3'd5, 5'h15, 4'h7, 1'b0, 9'h1FF, 9'h000, 1'b0);
    cmp("s2_valid", wr_p, 8'h00);
    cmp("s2_host", h_wr, 1'b1);
    cmp("s2_addr", h_addr, 5'h15);
    cmp("s2_inport", h_inport, 4'h7);
    cmp("s2_bufid", h_bufid, 9'h1A3);
    cmp("s2_cnt", bm_cnt, 5'd1);
    tick();
    cmp("s2_fwd", fwd_cnt, 16'd2);

    // lookup miss dropped
    send(9'h0AA, 3'd1, 5'd0, 4'd0, 1'b0, 9'h1FF, 9'h000, 1'b1);
    cmp("s3_bm_wr", bm_wr, 1'b1);
    cmp("s3_cnt", bm_cnt, 5'd0);
    cmp("s3_bufid", bm_bufid, 9'h0AA);
    cmp("s3_valid", {h_wr, wr_p}, 9'h000);
    cmp("s3_ready", dif.o_desc_ready, 1'b1);
    cmp("s3_drop", drop_cnt, 16'd1);
    tick();
    cmp("s3_bm_off", bm_wr, 1'b0);

    // full broadcast with port 3 stalled five cycles
    port_rdy[3] = 1'b0;
    send(9'h133, 3'd6, 5'd9, 4'd2, 1'b1, 9'h1FF, 9'h000, 1'b0);
    cmp("s4_valid", {h_wr, wr_p}, 9'h1FF);
    cmp("s4_cnt", bm_cnt, 5'd9);
    tick();
    cmp("s4_stall_valid", {h_wr, wr_p}, 9'h008);
    cmp("s4_stall_bufid", bufid_p[3*BW +: BW], 9'h133);
    tick();
    tick();
    tick();
    tick();
    cmp("s4_still_valid", wr_p, 8'h08);
    cmp("s4_still_bufid", bufid_p[3*BW +: BW], 9'h133);
    cmp("s4_busy", dif.o_desc_ready, 1'b0);
    port_rdy[3] = 1'b1;
    tick();
    cmp("s4_ready", dif.o_desc_ready, 1'b1);
    cmp("s4_valid_off", wr_p, 8'h00);
    cmp("s4_fwd", fwd_cnt, 16'd3);

    // reset in the middle of a dispatch
    port_rdy = '0;
    host_rdy = 1'b0;
    send(9'h0F0, 3'd3, 5'd4, 4'd5, 1'b1, 9'h0F0, 9'h000, 1'b0);
    cmp("s5_valid", wr_p, 8'hF0);
    rst = 1'b1;
    tick();
    cmp("s5_rst_valid", {h_wr, wr_p}, 9'h000);
    rst = 1'b0;
    port_rdy = '1;
    host_rdy = 1'b1;
    tick();
    cmp("s5_ready", dif.o_desc_ready, 1'b1);
    cmp("s5_fwd", fwd_cnt, 16'd0);
    cmp("s5_valid_off", wr_p, 8'h00);

    // random traffic, backpressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      dif.i_desc_valid   = ($urandom_range(0, 3) != 0);
      dif.iv_pkt_bufid   = BW'($urandom);
      dif.iv_pkt_type    = 3'($urandom);
      dif.iv_submit_addr = 5'($urandom);
      dif.iv_inport      = 4'($urandom);
      dif.i_outport_wr   = 1'($urandom);
      dif.i_miss_mode    = 1'($urandom);
      case ($urandom_range(0, 2))
        0: dif.iv_outport = '0;
        1: dif.iv_outport = NB'(1) << $urandom_range(0, PN);
        default: dif.iv_outport = NB'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0: dif.iv_ram_rdata = '0;
        1: dif.iv_ram_rdata = NB'(1) << $urandom_range(0, PN);
        default: dif.iv_ram_rdata = NB'($urandom);
      endcase
      port_rdy = PN'($urandom) | PN'($urandom);
      host_rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b1;
    dif.i_desc_valid = 1'b0;
    tick();
    rst = 1'b0;
    port_rdy = '1;
    host_rdy = 1'b1;
    tick();

    // 65536 back-to-back forwards wrap the counter
    dif.i_outport_wr = 1'b1;
    dif.iv_outport   = 9'h001;
    dif.i_desc_valid = 1'b1;
    start = total_fwd;
    for (int c = 0; c < 140000 && (total_fwd - start) < 65536; c++)
      tick();
    dif.i_desc_valid = 1'b0;
    cmp("wrap_forwards", 32'(total_fwd - start), 32'd65536);
    cmp("fwd_wrap", fwd_cnt, 16'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
